// File: rtl/spi_target_ex.sv
// SPI target for host access to the register bus: all four SPI modes, MSB-first words,
// multi-word frames with a saturating word counter. Optional overrun tracking: SPI_TARGET_OVERRUN_EN.
module spi_target_ex #(
  parameter int                WORD_W      = 8,
  parameter int                CPOL        = 0,
  parameter int                CPHA        = 0,
  parameter int                SYNC_STAGES = 2,
  parameter int                CNT_W       = 8,
  parameter logic [WORD_W-1:0] TX_IDLE     = '1
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              spi_sck_i,
  input  logic              spi_copi_i,
  output logic              spi_cipo_o,
  input  logic              spi_cs_i,
  output logic              select_o,
  output logic              frame_start_o,
  output logic              frame_end_o,
  output logic              rx_valid_o,
  output logic [WORD_W-1:0] rx_data_o,
  output logic              tx_load_o,
  input  logic [WORD_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
`ifdef SPI_TARGET_OVERRUN_EN
  input  logic              rx_ready_i,
  output logic              rx_overrun_o,
`endif
  output logic [CNT_W-1:0]  word_count_o
);

  localparam logic                SCK_IDLE = (CPOL != 0);
  localparam bit                  PHASE1   = (CPHA != 0);
  localparam int                  BIT_W    = $clog2(WORD_W);
  localparam logic [BIT_W-1:0]    LAST_BIT = BIT_W'(WORD_W - 1);

  logic [SYNC_STAGES-1:0] sck_sync, copi_sync, cs_sync;
  logic                   sck_prev;
  logic [BIT_W-1:0]       bit_cnt;
  logic [WORD_W-1:0]      rx_sr, tx_sr;

  logic              sck_norm, copi, sel;
  logic              leading, trailing, sample_edge, shift_edge, last_bit;
  logic              word_done, load_now, frame_begin, shift_bit;
  logic [WORD_W-1:0] rx_word, next_word;

  // NOTE: the synchroniser resets to idle pin levels so that releasing reset never looks like an SCK edge or a select.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
      copi_sync <= '0;
      cs_sync   <= '1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi_copi_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
    end
  end

  // Sampling happens on the leading edge in phase 0 and the trailing edge in phase 1;
  // the bit counter always advances on the trailing edge, where every bit ends.
  always_comb begin
    sck_norm    = sck_sync[SYNC_STAGES-1] ^ SCK_IDLE;
    copi        = copi_sync[SYNC_STAGES-1];
    sel         = ~cs_sync[SYNC_STAGES-1];
    leading     = sck_norm & ~sck_prev;
    trailing    = ~sck_norm & sck_prev;
    sample_edge = PHASE1 ? trailing : leading;
    shift_edge  = PHASE1 ? leading : trailing;
    last_bit    = (bit_cnt == LAST_BIT);
    word_done   = sel & sample_edge & last_bit;
    load_now    = ~sel | (trailing & last_bit);
    frame_begin = sel & ~select_o;
    rx_word     = {rx_sr[WORD_W-2:0], copi};
    next_word   = tx_valid_i ? tx_data_i : TX_IDLE;
    shift_bit   = PHASE1 ? tx_sr[WORD_W-1] : tx_sr[WORD_W-2];
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sck_prev      <= 1'b0;
      bit_cnt       <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      spi_cipo_o    <= TX_IDLE[WORD_W-1];
      select_o      <= 1'b0;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
      rx_valid_o    <= 1'b0;
      rx_data_o     <= '0;
      tx_load_o     <= 1'b0;
      word_count_o  <= '0;
`ifdef SPI_TARGET_OVERRUN_EN
      rx_overrun_o  <= 1'b0;
`endif
    end else begin
      sck_prev      <= sck_norm;
      select_o      <= sel;
      frame_start_o <= frame_begin;
      frame_end_o   <= ~sel & select_o;
      rx_valid_o    <= word_done;
      tx_load_o     <= load_now;

      if (word_done) rx_data_o <= rx_word;
      if (sel && sample_edge) rx_sr <= rx_word;

      if (!sel) bit_cnt <= '0;
      else if (trailing) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;

      if (load_now) begin
        tx_sr      <= next_word;
        spi_cipo_o <= next_word[WORD_W-1];
      end else if (shift_edge) begin
        tx_sr      <= {tx_sr[WORD_W-2:0], 1'b0};
        spi_cipo_o <= shift_bit;
      end

      if (frame_begin) word_count_o <= '0;
      else if (word_done && word_count_o != '1) word_count_o <= word_count_o + 1'b1;

`ifdef SPI_TARGET_OVERRUN_EN
      if (frame_begin) rx_overrun_o <= 1'b0;
      else if (rx_valid_o && !rx_ready_i) rx_overrun_o <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_spi_target_ex.sv
// Self-checking bench: drives one SPI initiator pattern into four targets (modes 0..3) in lockstep
// and compares against a word-level model of what the initiator sent and what the host offered.
module tb_spi_target_ex;

  localparam int H = 4;  // clk cycles per SCK half period (SCK = clk/8)

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck_n = 1'b0;
  logic copi_p0 = 1'b0, copi_p1 = 1'b0;
  logic cs = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic rx_ready = 1'b1;

  logic [3:0] sck_pin, copi_pin, cipo, sel, fs, fe, rxv, txl, ovr;
  logic [7:0] rx_data [4];
  logic [2:0] wc [4];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    assign sck_pin[m]  = sck_n ^ (m >= 2);
    assign copi_pin[m] = (m % 2 == 1) ? copi_p1 : copi_p0;
    spi_target_ex #(
      .WORD_W(8), .CPOL(m / 2), .CPHA(m % 2), .SYNC_STAGES(2), .CNT_W(3)
    ) u_dut (
      .clk(clk), .reset_i(reset),
      .spi_sck_i(sck_pin[m]), .spi_copi_i(copi_pin[m]), .spi_cipo_o(cipo[m]), .spi_cs_i(cs),
      .select_o(sel[m]), .frame_start_o(fs[m]), .frame_end_o(fe[m]),
      .rx_valid_o(rxv[m]), .rx_data_o(rx_data[m]), .tx_load_o(txl[m]),
      .tx_data_i(tx_data), .tx_valid_i(tx_valid),
`ifdef SPI_TARGET_OVERRUN_EN
      .rx_ready_i(rx_ready), .rx_overrun_o(ovr[m]),
`endif
      .word_count_o(wc[m])
    );
  end
`ifndef SPI_TARGET_OVERRUN_EN
  assign ovr = '0;
`endif

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event log per target, sampled away from the active edge.
  int rx_tot [4], fs_tot [4], fe_tot [4], tl_tot [4];
  logic [7:0] rx_log [4][32];
  initial for (int m = 0; m < 4; m++) begin
    rx_tot[m] = 0; fs_tot[m] = 0; fe_tot[m] = 0; tl_tot[m] = 0;
  end
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rxv[m]) begin
        rx_log[m][rx_tot[m] % 32] = rx_data[m];
        rx_tot[m]++;
      end
      if (fs[m]) fs_tot[m]++;
      if (fe[m]) fe_tot[m]++;
      if (txl[m] && sel[m]) tl_tot[m]++;
    end
  end

  // Frame model: words the initiator sends, words/valids the host offers per slot.
  logic [7:0] mosi_w [16];
  logic [7:0] miso_w [16];
  logic       miso_v [16];
  logic       ovr_exp = 1'b0;

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      mosi_w[i] = 8'($urandom);
      miso_w[i] = 8'($urandom);
      miso_v[i] = 1'($urandom);
    end
  endtask

  // One SPI bit on all four targets; returns what each initiator samples on cipo.
  task automatic send_bit(input logic b, output logic [3:0] smp);
    copi_p0 = b;
    repeat (H) @(negedge clk);
    smp[0] = cipo[0];
    smp[2] = cipo[2];
    sck_n = 1'b1;
    copi_p1 = b;
    repeat (H) @(negedge clk);
    smp[1] = cipo[1];
    smp[3] = cipo[3];
    sck_n = 1'b0;
  endtask

  task automatic run_frame(input int nw, input int last_bits);
    int nfull, nbits;
    int base [4], fs0 [4], fe0 [4], tl0 [4];
    logic [3:0] smp;
    logic [7:0] got [4][16];
    logic [7:0] exp_tx;
    nfull = (last_bits == 8) ? nw : nw - 1;
    for (int m = 0; m < 4; m++) begin
      base[m] = rx_tot[m]; fs0[m] = fs_tot[m]; fe0[m] = fe_tot[m]; tl0[m] = tl_tot[m];
    end
    tx_data = miso_w[0];
    tx_valid = miso_v[0];
    repeat (2 * H) @(negedge clk);
`ifdef SPI_TARGET_OVERRUN_EN
    for (int m = 0; m < 4; m++) check($sformatf("m%0d overrun_hold", m), ovr[m], ovr_exp);
`endif
    cs = 1'b0;
    repeat (H) @(negedge clk);
    for (int w = 0; w < nw; w++) begin
      nbits = (w == nw - 1) ? last_bits : 8;
      for (int b = 0; b < nbits; b++) begin
        send_bit(mosi_w[w][7-b], smp);
        for (int m = 0; m < 4; m++) got[m][w][7-b] = smp[m];
        if (b == 0) begin
          tx_data = miso_w[w+1];
          tx_valid = miso_v[w+1];
        end
      end
    end
    repeat (2 * H) @(negedge clk);
    cs = 1'b1;
    repeat (4 * H) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("m%0d rx_count", m), rx_tot[m] - base[m], nfull);
      for (int k = 0; k < nfull; k++) begin
        exp_tx = miso_v[k] ? miso_w[k] : 8'hFF;
        check($sformatf("m%0d rx_word%0d", m, k), rx_log[m][(base[m] + k) % 32], mosi_w[k]);
        check($sformatf("m%0d cipo_word%0d", m, k), got[m][k], exp_tx);
      end
      check($sformatf("m%0d word_count", m), wc[m], (nfull > 7) ? 7 : nfull);
      check($sformatf("m%0d frame_start", m), fs_tot[m] - fs0[m], 1);
      check($sformatf("m%0d frame_end", m), fe_tot[m] - fe0[m], 1);
      check($sformatf("m%0d tx_loads", m), tl_tot[m] - tl0[m], nfull);
      check($sformatf("m%0d select_idle", m), sel[m], 1'b0);
    end
    ovr_exp = !rx_ready && (nfull > 0);
`ifdef SPI_TARGET_OVERRUN_EN
    for (int m = 0; m < 4; m++) check($sformatf("m%0d overrun", m), ovr[m], ovr_exp);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("m%0d %s", m, tag),
            {sel[m], fs[m], fe[m], rxv[m], rx_data[m], txl[m], wc[m], cipo[m]}, 32'h1);
`ifdef SPI_TARGET_OVERRUN_EN
      check($sformatf("m%0d %s overrun", m, tag), ovr[m], 1'b0);
`endif
    end
  endtask

  initial begin
    logic [3:0] smp;
    repeat (3) @(negedge clk);
    check_reset_state("reset_state");
    reset = 1'b0;
    repeat (2 * H) @(negedge clk);

    // Mode smoke word: 0xA5 in, 0x3C out.
    fill_rand();
    mosi_w[0] = 8'hA5; miso_w[0] = 8'h3C; miso_v[0] = 1'b1;
    run_frame(1, 8);

    // Three-word frame with boundary patterns.
    fill_rand();
    mosi_w[0] = 8'h01; mosi_w[1] = 8'h80; mosi_w[2] = 8'hFF;
    run_frame(3, 8);

    // No valid TX data: idle fill on every slot.
    fill_rand();
    for (int i = 0; i < 16; i++) miso_v[i] = 1'b0;
    run_frame(2, 8);

    // Deselect after five bits of the second word.
    fill_rand();
    run_frame(2, 5);

    // Reset in the middle of a word.
    fill_rand();
    tx_data = miso_w[0]; tx_valid = miso_v[0];
    repeat (2 * H) @(negedge clk);
    cs = 1'b0;
    repeat (H) @(negedge clk);
    for (int b = 0; b < 3; b++) send_bit(mosi_w[0][7-b], smp);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midword_reset");
    cs = 1'b1;
    repeat (2 * H) @(negedge clk);
    reset = 1'b0;
    ovr_exp = 1'b0;
    repeat (2 * H) @(negedge clk);
    fill_rand();
    run_frame(2, 8);

    // Word counter saturation (3-bit counter, nine words).
    fill_rand();
    run_frame(9, 8);

    // Random frames.
    for (int f = 0; f < 4; f++) begin
      fill_rand();
      run_frame(1 + int'($urandom_range(3)), 8);
    end

`ifdef SPI_TARGET_OVERRUN_EN
    // Consumer not ready: overrun set, held across deselect, cleared by the next frame.
    fill_rand();
    rx_ready = 1'b0;
    run_frame(2, 8);
    rx_ready = 1'b1;
    fill_rand();
    run_frame(1, 8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
